// File: rtl/che_pkg.sv
// Shared definitions for the contrast-enhancement pipeline: interpolation
// mode encodings, default widths and a constant log2 helper.
package che_pkg;

  typedef enum logic [1:0] {
    CHE_IPL_BILIN = 2'd0,
    CHE_IPL_HOR   = 2'd1,
    CHE_IPL_VER   = 2'd2,
    CHE_IPL_BYP   = 2'd3
  } che_ipl_mode_e;

  localparam int CHE_DAT_WD   = 8;
  localparam int CHE_TILE_SIZ = 64;

  // Ceiling log2, usable in constant expressions.
  function automatic int che_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/che_bilin_ipl_pp_if.sv
// Stream interface of the bilinear interpolator: input beat with tile values
// and position, output pixel with frame tracking.
interface che_bilin_ipl_pp_if
  import che_pkg::*;
#(
  parameter int DAT_WD   = CHE_DAT_WD,
  parameter int TILE_SIZ = CHE_TILE_SIZ,
  parameter int CNT_WD   = 20
);
  localparam int PW = che_log2(TILE_SIZ);

  logic              vld_i;
  logic              rdy_o;
  logic [1:0]        mode_i;
  logic [PW-1:0]     pos_x_i;
  logic [PW-1:0]     pos_y_i;
  logic [DAT_WD-1:0] ul_dat_i;
  logic [DAT_WD-1:0] ur_dat_i;
  logic [DAT_WD-1:0] bl_dat_i;
  logic [DAT_WD-1:0] br_dat_i;
  logic              last_i;
  logic              vld_o;
  logic              rdy_i;
  logic [DAT_WD-1:0] dat_o;
  logic              last_o;
  logic [CNT_WD-1:0] pix_cnt_o;
  logic              done_o;

  // Upstream/downstream side (drives beats in, consumes pixels out).
  modport master (
    output vld_i, mode_i, pos_x_i, pos_y_i, ul_dat_i, ur_dat_i, bl_dat_i,
           br_dat_i, last_i, rdy_i,
    input  rdy_o, vld_o, dat_o, last_o, pix_cnt_o, done_o
  );

  // Interpolator side.
  modport slave (
    input  vld_i, mode_i, pos_x_i, pos_y_i, ul_dat_i, ur_dat_i, bl_dat_i,
           br_dat_i, last_i, rdy_i,
    output rdy_o, vld_o, dat_o, last_o, pix_cnt_o, done_o
  );

endinterface

// File: rtl/che_lerp2.sv
// Unsigned two-input weighted sum a*w0 + b*w1. The caller sizes O_WD so the
// sum cannot overflow for its weight range.
module che_lerp2 #(
  parameter int A_WD = 8,
  parameter int W_WD = 7,
  parameter int O_WD = 14
) (
  input  logic [A_WD-1:0] i_a,
  input  logic [A_WD-1:0] i_b,
  input  logic [W_WD-1:0] i_w0,
  input  logic [W_WD-1:0] i_w1,
  output logic [O_WD-1:0] o_sum
);

  logic [O_WD-1:0] w_pa;
  logic [O_WD-1:0] w_pb;

  assign w_pa  = O_WD'(i_a) * O_WD'(i_w0);
  assign w_pb  = O_WD'(i_b) * O_WD'(i_w1);
  assign o_sum = w_pa + w_pb;

endmodule

// File: rtl/che_bilin_ipl_pp.sv
// Back-pressurable 3-stage bilinear interpolator with per-pixel border modes
// and per-frame output pixel counting. A single global enable stalls the
// whole pipeline when the output holds a pixel the consumer does not take.
module che_bilin_ipl_pp
  import che_pkg::*;
#(
  parameter int DAT_WD   = CHE_DAT_WD,
  parameter int TILE_SIZ = CHE_TILE_SIZ,
  parameter int CNT_WD   = 20
) (
  input logic               clk,
  input logic               rstn,
  che_bilin_ipl_pp_if.slave bus
);

  localparam int PW     = che_log2(TILE_SIZ);
  localparam int WW     = PW + 1;
  localparam int TOP_WD = DAT_WD + PW;
  localparam int ACC_WD = DAT_WD + 2 * PW;
  localparam int HALF   = 1 << (2 * PW - 1);

  // Round half up, drop the 2*PW weight fraction bits, clamp to all-ones.
  function automatic logic [DAT_WD-1:0] rnd_sat(input logic [ACC_WD-1:0] acc);
    logic [ACC_WD:0] sum;
    logic [DAT_WD:0] q;
    sum = {1'b0, acc} + (ACC_WD + 1)'(HALF);
    q   = (DAT_WD + 1)'(sum >> (2 * PW));
    return q[DAT_WD] ? {DAT_WD{1'b1}} : q[DAT_WD-1:0];
  endfunction

  logic                 w_en;
  logic                 w_out_acc;
  che_ipl_mode_e        w_mode;
  logic [PW-1:0]        w_x;
  logic [PW-1:0]        w_y;
  logic [WW-1:0]        w_wx0;
  logic [WW-1:0]        w_wx1;
  logic [WW-1:0]        w_wy0;
  logic [WW-1:0]        w_wy1;
  logic [TOP_WD-1:0]    w_top;
  logic [TOP_WD-1:0]    w_bot;
  logic [ACC_WD-1:0]    w_acc;

  logic                 r_vld_p0;
  logic [TOP_WD-1:0]    r_top_p0;
  logic [TOP_WD-1:0]    r_bot_p0;
  logic [WW-1:0]        r_wy0_p0;
  logic [WW-1:0]        r_wy1_p0;
  logic                 r_last_p0;
  logic                 r_vld_p1;
  logic [ACC_WD-1:0]    r_acc_p1;
  logic                 r_last_p1;
  logic                 r_vld_p2;
  logic [DAT_WD-1:0]    r_dat_p2;
  logic                 r_last_p2;
  logic [CNT_WD-1:0]    r_cnt;
  logic                 r_done;

  assign w_en      = ~r_vld_p2 | bus.rdy_i;
  assign w_out_acc = r_vld_p2 & bus.rdy_i;
  assign w_mode    = che_ipl_mode_e'(bus.mode_i);

  // Border modes collapse the unused interpolation axis to weight 0.
  always_comb begin
    w_x = bus.pos_x_i;
    w_y = bus.pos_y_i;
    case (w_mode)
      CHE_IPL_BILIN: ;
      CHE_IPL_HOR:   w_y = '0;
      CHE_IPL_VER:   w_x = '0;
      CHE_IPL_BYP: begin
        w_x = '0;
        w_y = '0;
      end
    endcase
  end

  assign w_wx1 = {1'b0, w_x};
  assign w_wx0 = WW'(TILE_SIZ) - w_wx1;
  assign w_wy1 = {1'b0, w_y};
  assign w_wy0 = WW'(TILE_SIZ) - w_wy1;

  che_lerp2 #(.A_WD(DAT_WD), .W_WD(WW), .O_WD(TOP_WD)) u_lerp_top (
    .i_a  (bus.ul_dat_i),
    .i_b  (bus.ur_dat_i),
    .i_w0 (w_wx0),
    .i_w1 (w_wx1),
    .o_sum(w_top)
  );

  che_lerp2 #(.A_WD(DAT_WD), .W_WD(WW), .O_WD(TOP_WD)) u_lerp_bot (
    .i_a  (bus.bl_dat_i),
    .i_b  (bus.br_dat_i),
    .i_w0 (w_wx0),
    .i_w1 (w_wx1),
    .o_sum(w_bot)
  );

  che_lerp2 #(.A_WD(TOP_WD), .W_WD(WW), .O_WD(ACC_WD)) u_lerp_vert (
    .i_a  (r_top_p0),
    .i_b  (r_bot_p0),
    .i_w0 (r_wy0_p0),
    .i_w1 (r_wy1_p0),
    .o_sum(w_acc)
  );

  // Pipeline control: valid bits and the visible output advance together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_dat_p2  <= '0;
      r_last_p2 <= 1'b0;
    end else if (w_en) begin
      // S1 -> S2 -> S3 valid shift
      r_vld_p0  <= bus.vld_i;
      r_vld_p1  <= r_vld_p0;
      r_vld_p2  <= r_vld_p1;
      // S3: round, saturate, present
      r_dat_p2  <= rnd_sat(r_acc_p1);
      r_last_p2 <= r_last_p1 & r_vld_p1;
    end
  end

  // Pipeline datapath: unreset payload registers gated by the global enable.
  always_ff @(posedge clk) begin
    if (w_en) begin
      // S1: horizontal blends plus vertical weights
      r_top_p0  <= w_top;
      r_bot_p0  <= w_bot;
      r_wy0_p0  <= w_wy0;
      r_wy1_p0  <= w_wy1;
      r_last_p0 <= bus.last_i;
      // S2: vertical blend
      r_acc_p1  <= w_acc;
      r_last_p1 <= r_last_p0;
    end
  end

  // Frame tracking: count accepted pixels; after the last one, show the final
  // count together with the done pulse, then restart from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_out_acc & r_last_p2;
      if (r_done) begin
        r_cnt <= w_out_acc ? CNT_WD'(1) : '0;
      end else if (w_out_acc && (r_cnt != {CNT_WD{1'b1}})) begin
        r_cnt <= r_cnt + CNT_WD'(1);
      end
    end
  end

  assign bus.rdy_o     = w_en;
  assign bus.vld_o     = r_vld_p2;
  assign bus.dat_o     = r_dat_p2;
  assign bus.last_o    = r_last_p2;
  assign bus.pix_cnt_o = r_cnt;
  assign bus.done_o    = r_done;

endmodule

// File: tb/tb_che_bilin_ipl_pp.sv
// Directed bench for che_bilin_ipl_pp: vector table for the arithmetic and
// border modes, plus hand-written frame, backpressure and reset sequences.
module tb_che_bilin_ipl_pp;
  import che_pkg::*;

  localparam int DW = 8;
  localparam int TS = 64;
  localparam int CW = 20;
  localparam int PW = 6;
  localparam int NV = 11;

  typedef struct {
    che_ipl_mode_e mode;
    int x, y, ul, ur, bl, br, exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tv[NV];

  always #5 clk = ~clk;

  che_bilin_ipl_pp_if #(.DAT_WD(DW), .TILE_SIZ(TS), .CNT_WD(CW)) bus ();

  che_bilin_ipl_pp #(.DAT_WD(DW), .TILE_SIZ(TS), .CNT_WD(CW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_beat(input che_ipl_mode_e m, input int x, input int y,
                            input int ul, input int ur, input int bl, input int br,
                            input logic last);
    bus.vld_i    = 1'b1;
    bus.mode_i   = m;
    bus.pos_x_i  = PW'(x);
    bus.pos_y_i  = PW'(y);
    bus.ul_dat_i = DW'(ul);
    bus.ur_dat_i = DW'(ur);
    bus.bl_dat_i = DW'(bl);
    bus.br_dat_i = DW'(br);
    bus.last_i   = last;
  endtask

  task automatic run_vec(input int i);
    int n;
    bit seen;
    @(posedge clk); #1;
    drive_beat(tv[i].mode, tv[i].x, tv[i].y, tv[i].ul, tv[i].ur, tv[i].bl, tv[i].br, 1'b0);
    @(negedge clk);
    chk($sformatf("v%0d_rdy", i), 32'(bus.rdy_o), 1);
    @(posedge clk); #1;
    bus.vld_i = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.vld_o) seen = 1;
    end
    chk($sformatf("v%0d_latency", i), 32'(n), 3);
    chk($sformatf("v%0d_dat", i), 32'(bus.dat_o), 32'(tv[i].exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int exp_cnt[12];
    int done_seen;
    int idx, outn;
    bit stall_prev;
    logic [DW-1:0] prev_dat;
    int bp_exp[8];

    // mode, x, y, ul, ur, bl, br, expected
    tv[0]  = '{CHE_IPL_BILIN,  5,  9, 100, 100, 100, 100, 100};
    tv[1]  = '{CHE_IPL_BILIN, 32,  0,   0, 200,   0, 200, 100};
    tv[2]  = '{CHE_IPL_VER,   32,  0,   0, 200,   0, 200,   0};
    tv[3]  = '{CHE_IPL_BILIN, 32, 17,   0,   1,   0,   1,   1};
    tv[4]  = '{CHE_IPL_BILIN, 31, 17,   0,   1,   0,   1,   0};
    tv[5]  = '{CHE_IPL_BYP,   63, 63,   7, 255, 255, 255,   7};
    tv[6]  = '{CHE_IPL_HOR,   16, 40,  10,  50, 200, 200,  20};
    tv[7]  = '{CHE_IPL_BILIN, 16, 48,   0,  64, 128, 192, 112};
    tv[8]  = '{CHE_IPL_BILIN,  0,  0, 255, 255, 255, 255, 255};
    tv[9]  = '{CHE_IPL_BILIN,  1,  1, 255,   0,   0,   0, 247};
    tv[10] = '{CHE_IPL_VER,   50, 32, 100,   0, 200,   0, 150};

    exp_cnt = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 0, 0, 0};

    rstn = 1'b0;
    drive_beat(CHE_IPL_BILIN, 0, 0, 0, 0, 0, 0, 1'b0);
    bus.vld_i = 1'b0;
    bus.rdy_i = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_vld_o", 32'(bus.vld_o), 0);
    chk("rst_dat_o", 32'(bus.dat_o), 0);
    chk("rst_last_o", 32'(bus.last_o), 0);
    chk("rst_cnt", 32'(bus.pix_cnt_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_rdy_o", 32'(bus.rdy_o), 1);
    rstn = 1'b1;

    // Frame of 5 beats with last on the 5th
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 5) drive_beat(CHE_IPL_BYP, 0, 0, c * 10 + 1, 0, 0, 0, c == 4);
      else begin
        bus.vld_i  = 1'b0;
        bus.last_i = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("frm_cnt_c%0d", c), 32'(bus.pix_cnt_o), 32'(exp_cnt[c]));
      chk($sformatf("frm_done_c%0d", c), 32'(bus.done_o), 32'(c == 8));
      chk($sformatf("frm_last_c%0d", c), 32'(bus.last_o), 32'(c == 7));
      if (c >= 3 && c <= 7) chk($sformatf("frm_dat_c%0d", c), 32'(bus.dat_o), 32'((c - 3) * 10 + 1));
      if (bus.done_o) done_seen++;
    end
    chk("frm_done_pulses", 32'(done_seen), 1);

    // Vector table
    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: 8 beats, rdy_i low for cycles 4..9
    for (int k = 0; k < 8; k++) bp_exp[k] = 20 + 30 * k;
    idx = 0;
    outn = 0;
    stall_prev = 0;
    prev_dat = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bus.rdy_i = (c < 4) || (c > 9);
      if (idx < 8) begin
        if (idx % 2 == 0) drive_beat(CHE_IPL_BYP, 63, 63, bp_exp[idx], 255 - bp_exp[idx], 1, 2, 1'b0);
        else drive_beat(CHE_IPL_BILIN, idx * 7, idx * 5, bp_exp[idx], bp_exp[idx], bp_exp[idx], bp_exp[idx], 1'b0);
      end else begin
        bus.vld_i = 1'b0;
      end
      @(negedge clk);
      if (stall_prev) begin
        chk($sformatf("bp_hold_vld_c%0d", c), 32'(bus.vld_o), 1);
        chk($sformatf("bp_hold_dat_c%0d", c), 32'(bus.dat_o), 32'(prev_dat));
      end
      if (bus.vld_o && !bus.rdy_i) chk($sformatf("bp_rdy_o_c%0d", c), 32'(bus.rdy_o), 0);
      stall_prev = bus.vld_o && !bus.rdy_i;
      prev_dat = bus.dat_o;
      if (bus.vld_o && bus.rdy_i) begin
        if (outn < 8) chk($sformatf("bp_out%0d", outn), 32'(bus.dat_o), 32'(bp_exp[outn]));
        else chk("bp_extra_output", 32'(outn + 1), 8);
        outn++;
      end
      if (bus.vld_i && bus.rdy_o) idx++;
    end
    chk("bp_outputs", 32'(outn), 8);
    chk("bp_accepted", 32'(idx), 8);

    // Reset with two beats in flight (S3 stalled, S2 occupied)
    @(posedge clk); #1;
    bus.rdy_i = 1'b1;
    drive_beat(CHE_IPL_BYP, 0, 0, 33, 0, 0, 0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    drive_beat(CHE_IPL_BYP, 0, 0, 44, 0, 0, 0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    bus.vld_i = 1'b0;
    bus.rdy_i = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_pre_vld", 32'(bus.vld_o), 1);
    chk("rstmid_pre_dat", 32'(bus.dat_o), 33);
    chk("rstmid_pre_cnt", 32'(bus.pix_cnt_o), 19);
    #1 rstn = 1'b0;
    #1;
    chk("rstmid_vld", 32'(bus.vld_o), 0);
    chk("rstmid_cnt", 32'(bus.pix_cnt_o), 0);
    chk("rstmid_dat", 32'(bus.dat_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    bus.rdy_i = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.vld_o) stale++;
      end
      chk("rstmid_no_stale", 32'(stale), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/che_bilin_ipl_pp.md
Name: che_bilin_ipl_pp

Overview:
Parametrised, back-pressurable bilinear interpolator for the contrast-enhancement pipeline. It blends the four tile-mapped pixel values (ul/ur/bl/br) by the pixel's in-tile position and produces the final enhanced pixel. Compared with the fixed interpolator it adds a generic tile size and pixel width, per-pixel border modes, and valid/ready flow control. It also provides frame-end tracking with an output pixel counter. It sits between the CDF-map stage and the top-level output.

Parameters:
DAT_WD, 8, pixel width of the mapped inputs and of the output
TILE_SIZ, 64, tile edge in pixels; power of two, 4..256
PW, LOG2(TILE_SIZ), position width (derived, not overridable)
CNT_WD, 20, width of the per-frame output pixel counter

Ports:
clk  in  1  clock
rstn  in  1  reset
vld_i  in  1  input beat valid
rdy_o  out  1  input beat accepted when vld_i&rdy_o
mode_i  in  2  0 bilinear, 1 horizontal only (ul/ur), 2 vertical only (ul/bl), 3 bypass ul
pos_x_i  in  PW  horizontal offset from the left tile centre
pos_y_i  in  PW  vertical offset from the upper tile centre
ul_dat_i  in  DAT_WD  upper-left tile mapped value
ur_dat_i  in  DAT_WD  upper-right tile mapped value
bl_dat_i  in  DAT_WD  bottom-left tile mapped value
br_dat_i  in  DAT_WD  bottom-right tile mapped value
last_i  in  1  last pixel of the frame
vld_o  out  1  output valid
rdy_i  in  1  downstream ready
dat_o  out  DAT_WD  interpolated pixel
last_o  out  1  last_i aligned with dat_o
pix_cnt_o  out  CNT_WD  pixels output in the current frame
done_o  out  1  one-cycle pulse after the last pixel of the frame is accepted

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. All pipeline valid bits, vld_o, dat_o, last_o, pix_cnt_o and done_o reset to 0.
- Pipeline: 3 stages (S1, S2, S3). S3 drives the outputs. Latency is 3 cycles from acceptance to vld_o when there is no stall.
- Global enable: en = ~vld_o | rdy_i. rdy_o = en. When en=0 all stages hold their contents.
  - Every stage's valid and data advance only when en=1.
  - vld_o and dat_o stay stable while vld_o&~rdy_i.
- Mode pre-processing, before S1:
  - Mode 1 forces y to 0.
  - Mode 2 forces x to 0.
  - Mode 3 forces x and y to 0.
  - Mode 0 uses x and y as given.
- Weights: wx1 = x and wx0 = TILE_SIZ - x, width PW+1. wy1 and wy0 are formed the same way from y.
- S1: top = ul*wx0 + ur*wx1 and bot = bl*wx0 + br*wx1, each DAT_WD+PW bits, unsigned. Mode, last and wy0/wy1 are registered alongside.
- S2: acc = top*wy0 + bot*wy1, DAT_WD+2*PW bits.
- S3: res = (acc + 2^(2*PW-1)) >> 2*PW, i.e. round half up.
  - If the result exceeds 2^DAT_WD-1, saturate to all-ones. This is unreachable with legal inputs but is required anyway.
  - dat_o receives res. last_o receives the S2 last bit.
- Counter: pix_cnt_o increments on each vld_o&rdy_i.
  - It saturates at 2^CNT_WD-1 and never wraps.
  - On an accepted beat with last_o=1, pix_cnt_o clears to 0 in the next cycle and done_o pulses for 1 cycle.
- No bubble insertion is allowed: back-to-back accepted inputs produce back-to-back outputs when rdy_i is held high.
- With vld_i=0, stages collapse bubbles: an invalid S3 does not block, because en is 1 whenever vld_o=0.
- pos_x_i and pos_y_i are 0..TILE_SIZ-1. TILE_SIZ itself cannot be expressed, so there is no overflow case.
- Reset asserted mid-frame discards all in-flight beats and clears the counter. No output is produced for the discarded beats.

Decomposition:
- Shared package (che_pkg) holds:
  - mode encodings: CHE_IPL_BILIN, CHE_IPL_HOR, CHE_IPL_VER, CHE_IPL_BYP;
  - the LOG2 function or macro;
  - the default DAT_WD and TILE_SIZ.
- One sub-module, che_lerp2: a 2-input weighted sum a*w0 + b*w1 with parametrised widths.
  - Instantiated twice in S1.
  - Instantiated once in S2, with width DAT_WD+PW.

Test Plan:
- Flat tiles: DAT_WD=8, TILE_SIZ=64; ul=ur=bl=br=100, any x/y, mode 0 -> dat_o=100, vld_o exactly 3 cycles after acceptance.
- Horizontal midpoint: ul=bl=0, ur=br=200, x=32, y=0, mode 0 -> 100. Same inputs with mode 2 -> 0.
- Rounding: ul=bl=0, ur=br=1, x=32, y=17, mode 0 -> 1 (exact 0.5 rounds up). With x=31 -> 0.
- Bypass: ul=7, ur=bl=br=255, x=63, y=63, mode 3 -> 7.
- Backpressure: 8 consecutive beats; rdy_i low for cycles 4..9 -> all 8 values are output in order, none dropped or duplicated, dat_o stable while stalled, rdy_o low while stalled.
- Frame/reset:
  - 5 beats with last_i on the 5th -> pix_cnt_o counts 1..5, done_o pulses once, then pix_cnt_o=0.
  - Asserting rstn low with 2 beats in flight -> vld_o=0 immediately and no stale output after release.
